// File: rtl/mips_multicycle_control.sv
// Multi-cycle control sequencer for the single-register-file MIPS datapath.
// Owns pc and Instr, fetches over a req/ack port and drives datapath controls one phase per cycle.
module mips_multicycle_control #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        eq,
  output logic        imem_req,
  output logic [31:0] pc,
  output logic [31:0] Instr,
  output logic        Reg_Dst,
  output logic        Reg_Write,
  output logic        Alu_Src,
  output logic        Mem_Write,
  output logic        Mem_Read,
  output logic        Mem_To_Reg,
  output logic [3:0]  Alu_Control,
  output logic        retire,
  output logic        illegal
);

  // state  | meaning
  // IDLE   | waiting for run at an instruction boundary
  // FETCH  | imem_req held with pc stable until imem_ack
  // DECODE | classify Instr; j completes here
  // EXEC   | ALU phase; beq resolves and completes here
  // MEM    | lw reads, sw writes and completes
  // WB     | register write-back, completes
  // TRAP   | unsupported encoding seen; parked until reset
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
  typedef enum logic [2:0] {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_e;

  function automatic kind_e classify(input logic [31:0] ins);
    kind_e k;
    k = K_ILL;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A: k = K_R;
          default: k = K_ILL;
        endcase
      end
      6'h08:   k = K_ADDI;
      6'h23:   k = K_LW;
      6'h2B:   k = K_SW;
      6'h04:   k = K_BEQ;
      6'h02:   k = K_J;
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic logic [3:0] alu_op(input logic [31:0] ins);
    logic [3:0] op;
    op = 4'b0010;
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h22:   op = 4'b0110;
        6'h24:   op = 4'b0000;
        6'h25:   op = 4'b0001;
        6'h27:   op = 4'b1100;
        6'h2A:   op = 4'b0111;
        default: op = 4'b0010;
      endcase
    end else if (ins[31:26] == 6'h04) begin
      op = 4'b0110;
    end
    return op;
  endfunction

  state_e      state_q, state_d, boundary;
  kind_e       kind_q, kind_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d;
  logic        illegal_q, illegal_d, in_instr;
  logic        imem_req_q, imem_req_d, reg_dst_q, reg_dst_d, reg_write_q, reg_write_d;
  logic        alu_src_q, alu_src_d, mem_write_q, mem_write_d, mem_read_q, mem_read_d;
  logic        mem_to_reg_q, mem_to_reg_d, retire_q, retire_d;
  logic [3:0]  alu_control_q, alu_control_d;

  always_comb begin
    kind_q    = classify(instr_q);
    boundary  = run ? S_FETCH : S_IDLE;
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:  state_d = boundary;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (kind_q)
          K_J: begin
            pc_d    = {pc_q[31:28], instr_q[25:0], 2'b00};
            state_d = boundary;
          end
          K_ILL: begin
            illegal_d = 1'b1;
            state_d   = S_TRAP;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (kind_q)
          K_BEQ: begin
            // pc already points past the branch, so the offset is applied to PC+4
            if (eq) pc_d = pc_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
            state_d = boundary;
          end
          K_LW, K_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM:   state_d = (kind_q == K_LW) ? S_WB : boundary;
      S_WB:    state_d = boundary;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the state they describe.
    kind_d        = classify(instr_d);
    in_instr      = (state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB);
    imem_req_d    = (state_d == S_FETCH);
    reg_dst_d     = in_instr && (kind_d == K_R);
    alu_src_d     = in_instr && ((kind_d == K_ADDI) || (kind_d == K_LW) || (kind_d == K_SW));
    mem_to_reg_d  = in_instr && (kind_d != K_LW);
    alu_control_d = in_instr ? alu_op(instr_d) : 4'b0000;
    mem_read_d    = (kind_d == K_LW) && ((state_d == S_MEM) || (state_d == S_WB));
    mem_write_d   = (kind_d == K_SW) && (state_d == S_MEM);
    reg_write_d   = (state_d == S_WB);
    retire_d      = ((state_d == S_DECODE) && (kind_d == K_J)) ||
                    ((state_d == S_EXEC) && (kind_d == K_BEQ)) ||
                    ((state_d == S_MEM) && (kind_d == K_SW)) ||
                    (state_d == S_WB);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      illegal_q     <= 1'b0;
      imem_req_q    <= 1'b0;
      reg_dst_q     <= 1'b0;
      reg_write_q   <= 1'b0;
      alu_src_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      alu_control_q <= 4'b0000;
      retire_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      illegal_q     <= illegal_d;
      imem_req_q    <= imem_req_d;
      reg_dst_q     <= reg_dst_d;
      reg_write_q   <= reg_write_d;
      alu_src_q     <= alu_src_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
      mem_to_reg_q  <= mem_to_reg_d;
      alu_control_q <= alu_control_d;
      retire_q      <= retire_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign pc          = pc_q;
  assign Instr       = instr_q;
  assign Reg_Dst     = reg_dst_q;
  assign Reg_Write   = reg_write_q;
  assign Alu_Src     = alu_src_q;
  assign Mem_Write   = mem_write_q;
  assign Mem_Read    = mem_read_q;
  assign Mem_To_Reg  = mem_to_reg_q;
  assign Alu_Control = alu_control_q;
  assign retire      = retire_q;
  assign illegal     = illegal_q;

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle sequencer for the single-register-file MIPS datapath. It owns the program counter and instruction register and fetches words over a request/acknowledge instruction-memory port. It decodes a fixed MIPS subset and drives the datapath control inputs (register destination, register write, ALU source, ALU operation, memory read/write, write-back select) one phase per cycle. It sits between instruction memory and the datapath and uses the datapath's `eq` compare flag to resolve branches.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- run  in  1  enable; sampled at instruction boundaries.
- imem_ack  in  1  instruction word valid this cycle.
- imem_rdata  in  32  instruction word.
- eq  in  1  datapath compare flag, `rs == rt`.
- imem_req  out  1  fetch request.
- pc  out  32  current fetch address.
- Instr  out  32  latched instruction; feeds datapath `Instr`.
- Reg_Dst, Reg_Write, Alu_Src, Mem_Write, Mem_Read, Mem_To_Reg  out  1 each  datapath controls.
- Mem_To_Reg polarity: 1 selects ALU result, 0 selects memory data.
- Alu_Control  out  4  ALU operation.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  sticky; an unsupported opcode or funct was decoded.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset values:
  - state=IDLE, pc=RESET_PC, Instr=0.
  - All controls, imem_req, retire and illegal = 0.
  - Reset mid-instruction discards the instruction; no write strobe is issued.
- Boundary check: IDLE and every instruction boundary go to FETCH if run=1, else to IDLE.
- FETCH:
  - imem_req=1 with pc stable until imem_ack=1 at a clock edge.
  - On that edge: Instr<=imem_rdata, pc<=pc+4 (mod 2^32), go to DECODE.
  - imem_ack is ignored in every other state.
- DECODE: classify opcode and funct.
  - Supported R-type (opcode 0x00): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt.
  - Supported I-type: addi 0x08, lw 0x23, sw 0x2B, beq 0x04.
  - Supported J-type: j 0x02.
  - j: pc<=pc[31:28],Instr[25:0],2'b00; retire; boundary.
  - Any other encoding: illegal<=1, go to TRAP.
  - Everything else: go to EXEC.
- Alu_Control encoding: and 0000, or 0001, add 0010, sub 0110, slt 0111, nor 1100.
  - addi, lw, sw use add; beq uses sub.
- Static controls (from DECODE exit until the instruction retires):
  - Reg_Dst=1 for R-type only.
  - Alu_Src=1 for addi, lw, sw.
  - Mem_To_Reg=0 for lw, 1 otherwise.
  - All static controls are 0 outside an instruction.
- EXEC:
  - beq: if eq=1, pc<=pc+{Instr[15] sign-extended, Instr[15:0],2'b00}, mod 2^32; pc already holds PC+4. Retire; boundary.
  - lw, sw: go to MEM.
  - R-type, addi: go to WB.
- MEM:
  - lw: Mem_Read=1, go to WB.
  - sw: Mem_Write=1 for exactly this cycle; retire; boundary.
- WB:
  - Reg_Write=1 for exactly this cycle.
  - Mem_Read stays 1 for lw.
  - Retire; boundary.
- TRAP: all controls and imem_req 0; held until reset.
- Strobes are exclusive: at most one of Reg_Write and Mem_Write is 1 in any cycle.

## Timing
- Latency with imem_ack in the first FETCH cycle:
  - j: 2 cycles.
  - beq: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle of imem_ack delay adds one cycle.
- retire is asserted in the final cycle; the next FETCH starts on the following cycle.
- run=0 mid-instruction does not abort; the instruction completes, then the controller enters IDLE.
- From IDLE with run=1, FETCH starts on the next cycle.

## Test plan
- Reset: rst=0 mid-FETCH → pc=RESET_PC, all outputs 0, no Reg_Write or Mem_Write pulse.
- add $3,$1,$2 (0x00221820), ack immediate:
  - Cycles FETCH, DECODE, EXEC, WB.
  - WB: Reg_Dst=1, Alu_Control=0010, Mem_To_Reg=1, Reg_Write=1 for one cycle.
  - retire in WB; pc=4.
- lw $5,8($0) then sw $5,12($0):
  - lw: Mem_Read=1 in MEM and WB, Mem_To_Reg=0, Alu_Src=1, Reg_Write only in WB.
  - sw: Mem_Write=1 for exactly one cycle, Reg_Write never asserted.
- beq at pc=0x10 with offset 0xFFFF:
  - eq=1 → pc=0x10.
  - eq=0 → pc=0x14.
  - retire in EXEC in both cases.
- j 0x0000040 and imem_ack delayed 3 cycles:
  - pc and imem_req stay stable while waiting.
  - Then pc=0x100.
- Opcode 0x3F → illegal=1, controller in TRAP, imem_req held 0 until reset.
- run=0 asserted during EXEC: the instruction retires, the controller enters IDLE, and imem_req stays 0.
